// File: rtl/data_register_pkg.sv
// data_register_pkg: shared default width and reset value for data_register.
package data_register_pkg;
  localparam int DATA_REGISTER_WIDTH = 8;
  localparam logic [63:0] DATA_REGISTER_RESET_VALUE = '0;
endpackage

// File: rtl/data_register_if.sv
// data_register_if: load/data/status bundle; parity_out exists only with DATA_REGISTER_PARITY_EN.
interface data_register_if import data_register_pkg::*; #(
  parameter int WIDTH = DATA_REGISTER_WIDTH
);
  logic             load_signal;
  logic [WIDTH-1:0] data_input;
  logic [WIDTH-1:0] data_output;
  logic             loaded;
`ifdef DATA_REGISTER_PARITY_EN
  logic             parity_out;
  modport master (output load_signal, output data_input, input data_output, input loaded, input parity_out);
  modport slave  (input load_signal, input data_input, output data_output, output loaded, output parity_out);
`else
  modport master (output load_signal, output data_input, input data_output, input loaded);
  modport slave  (input load_signal, input data_input, output data_output, output loaded);
`endif
endinterface

// File: rtl/data_register_parity_gen.sv
// parity_gen: purely combinational even parity (XOR reduction) of a WIDTH-bit word.
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);
  assign o_parity = ^i_data;
endmodule

// File: rtl/data_register.sv
// data_register: loadable register with sync active-high reset and a sticky loaded flag.
// Optional parity_out is compiled in when DATA_REGISTER_PARITY_EN is defined.
module data_register import data_register_pkg::*; #(
  parameter int               WIDTH       = DATA_REGISTER_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = DATA_REGISTER_RESET_VALUE[WIDTH-1:0]
) (
  input logic            clk,
  input logic            reset,
  data_register_if.slave bus
);
  logic [WIDTH-1:0] r_data;
  logic             r_loaded;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_loaded <= 1'b0;
    end else if (bus.load_signal) begin
      r_data   <= bus.data_input;
      r_loaded <= 1'b1;
    end
  end
  assign bus.data_output = r_data;
  assign bus.loaded      = r_loaded;
`ifdef DATA_REGISTER_PARITY_EN
  logic w_parity;
  parity_gen #(.WIDTH(WIDTH)) u_parity (
    .i_data   (r_data),
    .o_parity (w_parity)
  );
  assign bus.parity_out = w_parity;
`endif
endmodule

// File: tb/tb_data_register.sv
// tb_data_register: directed and randomized checks of data_register against a behavioural model.
module tb_data_register;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset;
  data_register_if #(.WIDTH(W)) bus ();
  data_register #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] m_data;
  logic         m_loaded;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic r, input logic l, input logic [W-1:0] d);
    reset = r;
    bus.load_signal = l;
    bus.data_input = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_data = '0;
      m_loaded = 1'b0;
    end else if (l) begin
      m_data = d;
      m_loaded = 1'b1;
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".data"}, 64'(bus.data_output), 64'(m_data));
    check({tag, ".loaded"}, 64'(bus.loaded), 64'(m_loaded));
`ifdef DATA_REGISTER_PARITY_EN
    check({tag, ".parity"}, 64'(bus.parity_out), 64'($countones(m_data) % 2));
`endif
  endtask
  initial begin
    reset = 1'b0;
    bus.load_signal = 1'b0;
    bus.data_input = '0;
    m_data = '0;
    m_loaded = 1'b0;
    cycle(1'b1, 1'b1, 8'h55);
    check("reset_data", 64'(bus.data_output), 64'h00);
    check("reset_loaded", 64'(bus.loaded), 64'h0);
    cycle(1'b0, 1'b0, 8'b01010101);
    check("noload_data", 64'(bus.data_output), 64'h00);
    reset = 1'b0;
    bus.load_signal = 1'b1;
    bus.data_input = 8'hF0;
    @(negedge clk);
    #1;
    check("clklow_data", 64'(bus.data_output), 64'h00);
    bus.data_input = 8'b01010101;
    #1;
    check("midcycle_data", 64'(bus.data_output), 64'h00);
    @(posedge clk);
    #1;
    m_data = 8'h55;
    m_loaded = 1'b1;
    check("load55_data", 64'(bus.data_output), 64'h55);
    check("load55_loaded", 64'(bus.loaded), 64'h1);
    cycle(1'b0, 1'b0, 8'hAA);
    cycle(1'b0, 1'b0, 8'hAA);
    check("hold_data", 64'(bus.data_output), 64'h55);
    check("hold_loaded", 64'(bus.loaded), 64'h1);
    cycle(1'b0, 1'b1, 8'h12);
    check("b2b_12", 64'(bus.data_output), 64'h12);
    cycle(1'b0, 1'b1, 8'h34);
    check("b2b_34", 64'(bus.data_output), 64'h34);
`ifdef DATA_REGISTER_PARITY_EN
    cycle(1'b0, 1'b1, 8'h07);
    check("parity_07", 64'(bus.parity_out), 64'h1);
    cycle(1'b0, 1'b1, 8'h03);
    check("parity_03", 64'(bus.parity_out), 64'h0);
`endif
    cycle(1'b1, 1'b1, 8'hFF);
    check("rst_prio_data", 64'(bus.data_output), 64'h00);
    check("rst_prio_loaded", 64'(bus.loaded), 64'h0);
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(15) == 0, 1'($urandom), W'($urandom));
      check_all("rand");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
